// File: rtl/hilo_spec_pkg.sv
// Shared HI/LO definitions: write-mask type, queue entry layout and half selectors.
package hilo_spec_pkg;

    // Per-half write enable: bit1 = HI, bit0 = LO.
    typedef logic [1:0] hilo_mask_t;

    localparam hilo_mask_t HILO_MASK_HI = 2'b10;
    localparam hilo_mask_t HILO_MASK_LO = 2'b01;

    // Natural width of one half for the standard 32-bit core.
    localparam int HILO_DATA_WIDTH = 32;

    // One pending write as held in the queue.
    typedef struct packed {
        hilo_mask_t                     mask;
        logic [2*HILO_DATA_WIDTH-1:0]   data;
    } hilo_entry_t;

    // True when the mask enables the selected half.
    function automatic logic hilo_mask_has(input hilo_mask_t m, input hilo_mask_t sel);
        return |(m & sel);
    endfunction

endpackage

// File: rtl/hilo_spec_fwd.sv
// hilo_fwd: per-half priority selector picking the youngest pending write
// for each of HI and LO, falling back to the architectural value.
module hilo_fwd
    import hilo_spec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  hilo_mask_t                      entry_mask [DEPTH],
    input  logic [2*DATA_WIDTH-1:0]         entry_data [DEPTH],
    input  logic [DEPTH-1:0]                valid,
    input  logic [$clog2(DEPTH)-1:0]        wr_ptr,
    input  logic [2*DATA_WIDTH-1:0]         arch_data,
    output logic [2*DATA_WIDTH-1:0]         fwd_data
);

    localparam int PW = $clog2(DEPTH);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            logic [DATA_WIDTH-1:0] half_sel;
            logic [PW-1:0]         idx;

            // Walk oldest-to-youngest slot so the youngest matching entry wins.
            always_comb begin
                half_sel = arch_data[gi*DATA_WIDTH +: DATA_WIDTH];
                idx      = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    idx = wr_ptr - PW'(k + 1);
                    if (valid[idx] && entry_mask[idx][gi]) begin
                        half_sel = entry_data[idx][gi*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign fwd_data[gi*DATA_WIDTH +: DATA_WIDTH] = half_sel;
        end
    endgenerate

endmodule

// File: rtl/hilo_spec.sv
// hilo_spec: speculative HI/LO register pair with an in-order pending-write
// queue. Define HILO_FORWARD_EN to build youngest-entry forwarding on rddata;
// otherwise rddata mirrors the architectural value.
module hilo_spec
    import hilo_spec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [1:0]                      push_mask,
    input  logic [2*DATA_WIDTH-1:0]         push_data,
    input  logic                            commit,
    input  logic                            flush,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            commit_err,
    output logic [2*DATA_WIDTH-1:0]         rddata,
    output logic [2*DATA_WIDTH-1:0]         arch_rddata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = 2 * DATA_WIDTH;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] arch_q, arch_d;
    logic          commit_err_q, commit_err_d;

    hilo_mask_t    mask_mem [DEPTH];
    logic [WW-1:0] data_mem [DEPTH];

    logic push_ok;
    logic commit_ok;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign commit_err  = commit_err_q;
    assign arch_rddata = arch_q;

    // Next-state: commit retires before flush discards; pushes are dropped
    // in flush cycles and when full unless a commit frees a slot.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        arch_d       = arch_q;
        commit_ok    = commit && !empty;
        push_ok      = push && (!full || commit) && !flush;
        commit_err_d = commit && empty;

        if (commit_ok) begin
            if (hilo_mask_has(mask_mem[rd_ptr_q], HILO_MASK_HI)) begin
                arch_d[WW-1 -: DATA_WIDTH] = data_mem[rd_ptr_q][WW-1 -: DATA_WIDTH];
            end
            if (hilo_mask_has(mask_mem[rd_ptr_q], HILO_MASK_LO)) begin
                arch_d[DATA_WIDTH-1:0] = data_mem[rd_ptr_q][DATA_WIDTH-1:0];
            end
        end

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push_ok);
            rd_ptr_d = rd_ptr_q + PW'(commit_ok);
            count_d  = count_q + CW'(push_ok) - CW'(commit_ok);
        end
    end

    // Control and architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            arch_q       <= '0;
            commit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            arch_q       <= arch_d;
            commit_err_q <= commit_err_d;
        end
    end

    // Entry storage; stale slots are never read because validity gates every use.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mask_mem[wr_ptr_q] <= push_mask;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

`ifdef HILO_FORWARD_EN
    logic [DEPTH-1:0] valid;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            // A slot is pending when its distance from the read pointer is below count.
            assign valid[gi] = (CW'(PW'(gi) - rd_ptr_q) < count_q);
        end
    endgenerate

    hilo_fwd #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd (
        .entry_mask (mask_mem),
        .entry_data (data_mem),
        .valid      (valid),
        .wr_ptr     (wr_ptr_q),
        .arch_data  (arch_q),
        .fwd_data   (rddata)
    );
`else
    assign rddata = arch_q;
`endif

endmodule
